// File: rtl/monitor_readback_gen_if.sv
// Purpose: UART-side handshake bundle for the monitor readback serialiser.
// Signals: tx_en / tx_data_loaded toward the serialiser; tx_data_ready, tx_data,
//          tx_complete and busy back from it. master = serialiser, slave = sequencer/UART.
interface monitor_readback_gen_if;
    logic       tx_en;
    logic       tx_data_loaded;
    logic       tx_data_ready;
    logic [6:0] tx_data;
    logic       tx_complete;
    logic       busy;

    modport master (
        input  tx_en,
        input  tx_data_loaded,
        output tx_data_ready,
        output tx_data,
        output tx_complete,
        output busy
    );

    modport slave (
        output tx_en,
        output tx_data_loaded,
        input  tx_data_ready,
        input  tx_data,
        input  tx_complete,
        input  busy
    );
endinterface

// File: rtl/monitor_readback_gen.sv
// Purpose: snapshot N_CH readback channels and stream them to the UART as 7-bit
//          words (optional header, data MS chunk first, optional XOR checksum).
// Latency: tx_en -> first word valid after 2 edges; ack edge -> ready low after 2 edges.
// Backpressure: one word in flight; next word only after the synchronised ack drops.
// Ports: clk, rst (async, active-high), rb_bus (N_CH*RB_WIDTH readbacks),
//        tx (handshake interface, master side).
module monitor_readback_gen #(
    parameter int         N_CH        = 15,
    parameter int         RB_WIDTH    = 7,
    parameter int         HEADER_EN   = 1,
    parameter logic [6:0] HEADER_WORD = 7'h55,
    parameter int         CKSUM_EN    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH*RB_WIDTH-1:0] rb_bus,
    monitor_readback_gen_if.master   tx
);

    localparam int WPC      = (RB_WIDTH + 6) / 7;
    localparam int PW       = WPC * 7;
    localparam int N_DATA   = N_CH * WPC;
    localparam int DATA_END = HEADER_EN + N_DATA;
    localparam int TOTAL    = HEADER_EN + N_DATA + CKSUM_EN;
    localparam int IDX_W    = $clog2(TOTAL + 1);
    localparam int BUS_W    = N_CH * RB_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_PRESENT,
        S_RELEASE,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [BUS_W-1:0] sync_a, sync_b;
    logic [BUS_W-1:0] snapshot, snap_nxt;
    logic             ld1, ld2, ld_clr;
    logic [IDX_W-1:0] word_idx, idx_nxt;
    logic [6:0]       cksum, ck_nxt;
    logic [6:0]       tx_data_q, dat_nxt;
    logic             rdy_q, rdy_nxt;
    logic             cmp_q, cmp_nxt;

    // Input synchronisers. The ack comes from the baud domain; only ld2 is used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
            ld1    <= 1'b0;
            ld2    <= 1'b0;
        end else begin
            sync_a <= rb_bus;
            sync_b <= sync_a;
            ld1    <= ld_clr ? 1'b0 : tx.tx_data_loaded;
            ld2    <= ld_clr ? 1'b0 : ld1;
        end
    end

    // Flatten the snapshot into the transmit word list: each channel is zero
    // padded up to a whole number of 7-bit chunks, most significant chunk first.
    logic [6:0] data_words [N_DATA];

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [PW-1:0] pad;
        assign pad = PW'(snapshot[c*RB_WIDTH +: RB_WIDTH]);
        for (genvar k = 0; k < WPC; k++) begin : g_w
            assign data_words[c*WPC + k] = pad[(WPC-1-k)*7 +: 7];
        end
    end

    logic             is_hdr, is_ck, is_data;
    logic [IDX_W-1:0] data_idx;
    logic [6:0]       cur_word;

    always_comb begin
        is_hdr   = (HEADER_EN != 0) && (word_idx == '0);
        is_ck    = (CKSUM_EN != 0) && (word_idx == IDX_W'(TOTAL - 1));
        is_data  = !is_hdr && !is_ck && (word_idx < IDX_W'(DATA_END));
        data_idx = word_idx - IDX_W'(HEADER_EN);
        cur_word = '0;
        for (int i = 0; i < N_DATA; i++) begin
            if (data_idx == IDX_W'(i)) cur_word = data_words[i];
        end
        if (is_ck)  cur_word = cksum;
        if (is_hdr) cur_word = HEADER_WORD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        snap_nxt  = snapshot;
        idx_nxt   = word_idx;
        ck_nxt    = cksum;
        dat_nxt   = tx_data_q;
        rdy_nxt   = rdy_q;
        cmp_nxt   = cmp_q;
        ld_clr    = 1'b0;

        case (state)
            S_IDLE: begin
                if (tx.tx_en) begin
                    snap_nxt  = sync_b;
                    idx_nxt   = '0;
                    ck_nxt    = '0;
                    state_nxt = S_ARM;
                end
            end
            S_ARM: begin
                if (!tx.tx_en) begin
                    rdy_nxt   = 1'b0;
                    cmp_nxt   = 1'b0;
                    state_nxt = S_IDLE;
                end else if (!ld2) begin
                    // Holding off while ld2 is high keeps a stale ack from
                    // consuming the first word.
                    dat_nxt   = cur_word;
                    rdy_nxt   = 1'b1;
                    state_nxt = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (!tx.tx_en) begin
                    rdy_nxt   = 1'b0;
                    cmp_nxt   = 1'b0;
                    state_nxt = S_IDLE;
                end else if (ld2) begin
                    rdy_nxt   = 1'b0;
                    idx_nxt   = word_idx + 1'b1;
                    if (is_data) ck_nxt = cksum ^ tx_data_q;
                    state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!tx.tx_en) begin
                    rdy_nxt   = 1'b0;
                    cmp_nxt   = 1'b0;
                    state_nxt = S_IDLE;
                end else if (!ld2) begin
                    if (word_idx == IDX_W'(TOTAL)) begin
                        cmp_nxt   = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        dat_nxt   = cur_word;
                        rdy_nxt   = 1'b1;
                        state_nxt = S_PRESENT;
                    end
                end
            end
            S_DONE: begin
                cmp_nxt = 1'b1;
                if (!tx.tx_en) begin
                    cmp_nxt   = 1'b0;
                    ld_clr    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snapshot  <= '0;
            word_idx  <= '0;
            cksum     <= '0;
            tx_data_q <= '0;
            rdy_q     <= 1'b0;
            cmp_q     <= 1'b0;
        end else begin
            snapshot  <= snap_nxt;
            word_idx  <= idx_nxt;
            cksum     <= ck_nxt;
            tx_data_q <= dat_nxt;
            rdy_q     <= rdy_nxt;
            cmp_q     <= cmp_nxt;
        end
    end

    assign tx.tx_data_ready = rdy_q;
    assign tx.tx_data       = tx_data_q;
    assign tx.tx_complete   = cmp_q;
    assign tx.busy          = (state != S_IDLE);

endmodule

// File: tb/tb_monitor_readback_gen.sv
// Purpose: directed bench for monitor_readback_gen, default build plus a
//          2-channel 12-bit build without header.
// Drives inputs 1 ns after the rising edge and samples outputs at the same point.
module tb_monitor_readback_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15*7-1:0] rb_a;
    logic [23:0]     rb_b;

    monitor_readback_gen_if ifa ();
    monitor_readback_gen_if ifb ();

    monitor_readback_gen dut_a (
        .clk    (clk),
        .rst    (rst),
        .rb_bus (rb_a),
        .tx     (ifa)
    );

    monitor_readback_gen #(
        .N_CH      (2),
        .RB_WIDTH  (12),
        .HEADER_EN (0)
    ) dut_b (
        .clk    (clk),
        .rst    (rst),
        .rb_bus (rb_b),
        .tx     (ifb)
    );

    int         n_chk = 0;
    int         n_err = 0;
    int         cmp_cnt_a = 0;
    logic [6:0] exp_w [0:16];

    always @(posedge clk) cmp_cnt_a <= cmp_cnt_a + int'(ifa.tx_complete);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic g_rdy(input bit s);
        return s ? ifb.tx_data_ready : ifa.tx_data_ready;
    endfunction
    function automatic logic [6:0] g_dat(input bit s);
        return s ? ifb.tx_data : ifa.tx_data;
    endfunction
    function automatic logic g_cmp(input bit s);
        return s ? ifb.tx_complete : ifa.tx_complete;
    endfunction

    task automatic set_ld(input bit s, input logic v);
        if (s) ifb.tx_data_loaded = v;
        else   ifa.tx_data_loaded = v;
    endtask

    task automatic set_rb_a(input logic [6:0] base);
        for (int c = 0; c < 15; c++) rb_a[c*7 +: 7] = base + 7'(c);
    endtask

    // Header, channel values base..base+14, XOR of the data words only.
    task automatic build_exp_a(input logic [6:0] base);
        logic [6:0] ck;
        ck = '0;
        exp_w[0] = 7'h55;
        for (int c = 0; c < 15; c++) begin
            exp_w[c+1] = base + 7'(c);
            ck         = ck ^ exp_w[c+1];
        end
        exp_w[16] = ck;
    endtask

    task automatic wait_rdy(input bit s, input logic v);
        int n;
        n = 0;
        while (g_rdy(s) !== v && n < 300) begin
            tick;
            n++;
        end
        chk(v ? "rdy_rise" : "rdy_fall", 32'(g_rdy(s)), 32'(v));
    endtask

    // Acknowledge n words like the UART would and check each one.
    // timing=1 checks the exact ack/release cycle counts.
    // chg=i overwrites every channel with 7'h7F once word i is accepted.
    task automatic stream(input bit s, input int n, input int hold, input bit timing,
                          input int chg, input bit done);
        for (int i = 0; i < n; i++) begin
            wait_rdy(s, 1'b1);
            chk($sformatf("word%0d", i), 32'(g_dat(s)), 32'(exp_w[i]));
            set_ld(s, 1'b1);
            if (timing) begin
                tick; chk("ack_m",   32'(g_rdy(s)), 32'd1);
                tick; chk("ack_m1",  32'(g_rdy(s)), 32'd1);
                tick; chk("ack_m2",  32'(g_rdy(s)), 32'd0);
                set_ld(s, 1'b0);
                tick; chk("rel_n",   32'(g_rdy(s)), 32'd0);
                tick; chk("rel_n1",  32'(g_rdy(s)), 32'd0);
                tick;
                if (i < n - 1) chk("rel_n2", 32'(g_rdy(s)), 32'd1);
                else           chk("cmp_n2", 32'(g_cmp(s)), 32'd1);
            end else begin
                repeat (hold) tick;
                wait_rdy(s, 1'b0);
                set_ld(s, 1'b0);
            end
            if (i == chg) for (int c = 0; c < 15; c++) rb_a[c*7 +: 7] = 7'h7F;
        end
        if (done) begin
            int k;
            k = 0;
            while (g_cmp(s) !== 1'b1 && k < 300) begin
                tick;
                k++;
            end
            chk("complete", 32'(g_cmp(s)), 32'd1);
            chk("rdy_at_done", 32'(g_rdy(s)), 32'd0);
        end
    endtask

    initial begin
        int c0;
        ifa.tx_en = 1'b0; ifa.tx_data_loaded = 1'b0;
        ifb.tx_en = 1'b0; ifb.tx_data_loaded = 1'b0;
        rb_a = '0;
        rb_b = '0;

        // Reset state
        tick; tick;
        chk("rst_rdy_a",  32'(ifa.tx_data_ready), 32'd0);
        chk("rst_dat_a",  32'(ifa.tx_data),       32'd0);
        chk("rst_cmp_a",  32'(ifa.tx_complete),   32'd0);
        chk("rst_busy_a", 32'(ifa.busy),          32'd0);
        chk("rst_rdy_b",  32'(ifb.tx_data_ready), 32'd0);
        chk("rst_busy_b", 32'(ifb.busy),          32'd0);
        rst = 1'b0;
        tick;

        // Default build, channel c = c+1, cycle-exact handshake. XOR of 1..15 is 0.
        set_rb_a(7'd1);
        build_exp_a(7'd1);
        repeat (3) tick;
        ifa.tx_en = 1'b1;
        tick;
        chk("busy_k",  32'(ifa.busy),          32'd1);
        chk("rdy_k",   32'(ifa.tx_data_ready), 32'd0);
        tick;
        chk("rdy_k1",  32'(ifa.tx_data_ready), 32'd1);
        chk("dat_k1",  32'(ifa.tx_data),       32'h55);
        stream(1'b0, 17, 1, 1'b1, -1, 1'b1);
        ifa.tx_en = 1'b0;
        tick;
        chk("cmp_drop",  32'(ifa.tx_complete), 32'd0);
        chk("busy_drop", 32'(ifa.busy),        32'd0);

        // 2 x 12-bit build, no header: 0xABC -> 0x15,0x3C ; 0x001 -> 0x00,0x01 ; cksum 0x28
        rb_b = {12'h001, 12'hABC};
        exp_w[0] = 7'h15; exp_w[1] = 7'h3C; exp_w[2] = 7'h00;
        exp_w[3] = 7'h01; exp_w[4] = 7'h28;
        repeat (3) tick;
        ifb.tx_en = 1'b1;
        stream(1'b1, 5, 1, 1'b0, -1, 1'b1);
        ifb.tx_en = 1'b0;
        tick;
        chk("b_busy_drop", 32'(ifb.busy), 32'd0);

        // Snapshot freeze: bus goes to 0x7F after the header is accepted.
        set_rb_a(7'd1);
        build_exp_a(7'd1);
        repeat (3) tick;
        ifa.tx_en = 1'b1;
        stream(1'b0, 17, 2, 1'b0, 0, 1'b1);
        ifa.tx_en = 1'b0;
        tick;

        // Abort while the third word is presented, then restart with a new snapshot.
        set_rb_a(7'd1);
        build_exp_a(7'd1);
        repeat (3) tick;
        ifa.tx_en = 1'b1;
        c0 = cmp_cnt_a;
        stream(1'b0, 2, 1, 1'b0, -1, 1'b0);
        wait_rdy(1'b0, 1'b1);
        chk("abort_word", 32'(ifa.tx_data), 32'h02);
        ifa.tx_en = 1'b0;
        tick;
        chk("abort_rdy",  32'(ifa.tx_data_ready), 32'd0);
        chk("abort_busy", 32'(ifa.busy),          32'd0);
        repeat (5) tick;
        chk("abort_cmp", 32'(cmp_cnt_a - c0), 32'd0);
        set_rb_a(7'h11);
        build_exp_a(7'h11);
        repeat (3) tick;
        ifa.tx_en = 1'b1;
        stream(1'b0, 17, 1, 1'b0, -1, 1'b1);
        ifa.tx_en = 1'b0;
        tick;

        // Asynchronous reset mid-transfer. The synchronisers restart from zero,
        // so the stream after release carries an all-zero snapshot.
        set_rb_a(7'd1);
        build_exp_a(7'd1);
        repeat (3) tick;
        ifa.tx_en = 1'b1;
        stream(1'b0, 3, 1, 1'b0, -1, 1'b0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_rdy",  32'(ifa.tx_data_ready), 32'd0);
        chk("mid_rst_dat",  32'(ifa.tx_data),       32'd0);
        chk("mid_rst_cmp",  32'(ifa.tx_complete),   32'd0);
        chk("mid_rst_busy", 32'(ifa.busy),          32'd0);
        @(posedge clk);
        #5 rst = 1'b0;
        build_exp_a(7'd0);
        for (int c = 1; c < 17; c++) exp_w[c] = 7'h00;
        stream(1'b0, 17, 1, 1'b0, -1, 1'b1);
        ifa.tx_en = 1'b0;
        tick;

        // Long ack: tx_data_loaded held 50 cycles per word.
        set_rb_a(7'd1);
        build_exp_a(7'd1);
        repeat (3) tick;
        ifa.tx_en = 1'b1;
        stream(1'b0, 17, 50, 1'b0, -1, 1'b1);
        ifa.tx_en = 1'b0;
        tick;
        chk("long_cmp_drop", 32'(ifa.tx_complete), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
